// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Strobe codes match the encodings understood by data_mem.
package dmem_arb_pkg;

   typedef enum logic {
      S_SHARED = 1'b0,
      S_LOCK   = 1'b1
   } arb_state_e;

   localparam logic [3:0] STRB_B  = 4'b0001;
   localparam logic [3:0] STRB_H  = 4'b0011;
   localparam logic [3:0] STRB_W  = 4'b1111;
   localparam logic [3:0] STRB_BU = 4'b1001;
   localparam logic [3:0] STRB_HU = 4'b1011;

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data_mem between the core and the DMA/debug port.
// Core has priority; DMA gets a starvation guarantee and optional bounded lock bursts.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4,
   parameter int LOCK_MAX   = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          core_req,
   input  logic          core_we,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   input  logic [3:0]    core_wstrb,
   input  logic [3:0]    core_lstrb,
   output logic          core_gnt,
   output logic          core_rvalid,
   output logic [DW-1:0] core_rdata,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic          dma_lock,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   input  logic [3:0]    dma_wstrb,
   input  logic [3:0]    dma_lstrb,
   output logic          dma_gnt,
   output logic          dma_rvalid,
   output logic [DW-1:0] dma_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   output logic [3:0]    mem_wstrb,
   output logic [3:0]    mem_wstrb_load,
   input  logic [DW-1:0] mem_rdata
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam int LW = $clog2(LOCK_MAX + 1);
   localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
   localparam logic [LW-1:0] LOCK_TOP   = LW'(LOCK_MAX);

   arb_state_e    state, state_nxt;
   logic [SW-1:0] starve_cnt, starve_nxt;
   logic [LW-1:0] lock_cnt, lock_nxt;
   logic          starve_full, lock_full, lock_hold;

   always_comb begin
      starve_full = (starve_cnt == STARVE_TOP);
      lock_full   = (lock_cnt == LOCK_TOP);
      lock_hold   = (state == S_LOCK) && dma_req && dma_lock && !lock_full;
      core_gnt    = 1'b0;
      dma_gnt     = 1'b0;
      state_nxt   = state;
      starve_nxt  = starve_cnt;
      lock_nxt    = lock_cnt;
      if (lock_hold) begin
         dma_gnt    = 1'b1;
         lock_nxt   = lock_cnt + LW'(1);
         starve_nxt = '0;
      end else begin
         // Shared arbitration also decides the cycle that leaves a lock burst.
         if (dma_req && starve_full) dma_gnt = 1'b1;
         else if (core_req)          core_gnt = 1'b1;
         else if (dma_req)           dma_gnt = 1'b1;
         if (dma_gnt && dma_lock) begin
            state_nxt = S_LOCK;
            lock_nxt  = LW'(1);
         end else begin
            state_nxt = S_SHARED;
            lock_nxt  = '0;
         end
         // A forced burst end restarts the starvation window so the core gets its turn.
         if (dma_gnt || !dma_req || (state == S_LOCK && lock_full)) starve_nxt = '0;
         else if (!starve_full)                                    starve_nxt = starve_cnt + SW'(1);
      end
      if (rst) begin
         core_gnt = 1'b0;
         dma_gnt  = 1'b0;
      end
   end

   always_comb begin
      mem_addr       = '0;
      mem_wdata      = '0;
      mem_we         = 1'b0;
      mem_wstrb      = '0;
      mem_wstrb_load = '0;
      if (core_gnt) begin
         mem_addr       = core_addr;
         mem_wdata      = core_wdata;
         mem_we         = core_we;
         mem_wstrb      = core_wstrb;
         mem_wstrb_load = core_lstrb;
      end else if (dma_gnt) begin
         mem_addr       = dma_addr;
         mem_wdata      = dma_wdata;
         mem_we         = dma_we;
         mem_wstrb      = dma_wstrb;
         mem_wstrb_load = dma_lstrb;
      end
   end

   // Stage boundary: arbitration state and registered read response
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_SHARED;
         starve_cnt  <= '0;
         lock_cnt    <= '0;
         core_rvalid <= 1'b0;
         dma_rvalid  <= 1'b0;
         core_rdata  <= '0;
         dma_rdata   <= '0;
      end else begin
         state       <= state_nxt;
         starve_cnt  <= starve_nxt;
         lock_cnt    <= lock_nxt;
         core_rvalid <= core_gnt && !core_we;
         dma_rvalid  <= dma_gnt && !dma_we;
         if (core_gnt && !core_we) core_rdata <= mem_rdata;
         if (dma_gnt && !dma_we)   dma_rdata  <= mem_rdata;
      end
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port `data_mem` between the core load/store path and a DMA/debug loader port. Sits between the requesters and `data_mem`: it drives the memory's address, write data, write enable, store strobe and load strobe; returns a registered read response to the granted requester. Core has priority. The DMA port is protected from starvation and may lock the memory for bounded bursts.

## Interface
- `AW`, 32, address width (memory uses bits [9:2])
- `DW`, 32, data width
- `STARVE_MAX`, 4, core-won cycles a pending DMA request tolerates before forced DMA grant (≥1)
- `LOCK_MAX`, 8, maximum consecutive locked DMA grants (≥2)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `core_req`, `core_we`  in  1  core request / write-not-read
- `core_addr`  in  AW  byte address
- `core_wdata`  in  DW  store data
- `core_wstrb`, `core_lstrb`  in  4  store strobe / load strobe (codes 0001, 0011, 1111, 1001, 1011)
- `core_gnt`  out  1  combinational grant; core stalls while `core_req && !core_gnt`
- `core_rvalid`  out  1  read data valid, one cycle after granted read
- `core_rdata`  out  DW  registered read data
- `dma_req`, `dma_we`, `dma_lock`, `dma_addr`, `dma_wdata`, `dma_wstrb`, `dma_lstrb`, `dma_gnt`, `dma_rvalid`, `dma_rdata`: same as core, plus `dma_lock` in 1 (request burst ownership)
- `mem_addr` out AW, `mem_wdata` out DW, `mem_we` out 1, `mem_wstrb` out 4, `mem_wstrb_load` out 4: to `data_mem`
- `mem_rdata`  in  DW  combinational read data from `data_mem`

## Operation
- One transaction per cycle; at most one of `core_gnt`/`dma_gnt` high.
- Memory outputs are a pure mux of the granted requester's fields. No grant: `mem_we`=0, all other `mem_*` outputs 0.
- Requester holds all fields stable while `req && !gnt`. Fields are sampled only in the granted cycle.
- States: `S_SHARED` (reset), `S_LOCK`.
- `S_SHARED` grant rule, in priority order:
  - `dma_req && starve_cnt==STARVE_MAX` → DMA.
  - `core_req` → core.
  - `dma_req` → DMA.
- `starve_cnt` (0..STARVE_MAX, saturating):
  - +1 each cycle `dma_req && !dma_gnt`.
  - Cleared on DMA grant or when `dma_req`=0.
- `S_SHARED`→`S_LOCK` when DMA is granted with `dma_lock`=1; `lock_cnt` loads 1.
- `S_LOCK`:
  - DMA granted every cycle `dma_req`=1; core never granted.
  - `lock_cnt` +1 per cycle.
  - Exit to `S_SHARED` when `dma_req`=0, `dma_lock`=0, or `lock_cnt==LOCK_MAX`.
  - Exit cycle itself grants per the `S_SHARED` rule.
  - Forced exit (`lock_cnt==LOCK_MAX`) clears `starve_cnt` so a waiting core wins the next cycle.
- Read response: on a granted read (`we`=0), at the clock edge, `mem_rdata` is captured into that requester's `rdata` and `rvalid` pulses high for exactly one cycle. The other requester's `rdata` holds its value. Writes produce no `rvalid`.
- Illegal strobe codes pass through unchanged; `data_mem` defines their effect.

## Timing
- Grant: combinational from requests and current state, zero latency.
- Writes commit at the edge ending the granted cycle (inside `data_mem`).
- Read latency: `rvalid`/`rdata` one cycle after grant. Back-to-back reads give `rvalid` on consecutive cycles.
- Reset values: state `S_SHARED`, `starve_cnt`=0, `lock_cnt`=0, `core_rvalid`=`dma_rvalid`=0, `core_rdata`=`dma_rdata`=0.
- Reset asserted mid-lock or with a read in flight: next cycle is `S_SHARED` with no `rvalid`. Grants are masked to 0 while `rst`=1.
- Simultaneous requests with `starve_cnt`<STARVE_MAX: core wins.
- `dma_lock` with a starvation-forced grant also enters `S_LOCK`.

## Structure
- Package `dmem_arb_pkg`:
  - state enum (`S_SHARED`, `S_LOCK`)
  - strobe constants `STRB_B`=0001, `STRB_H`=0011, `STRB_W`=1111, `STRB_BU`=1001, `STRB_HU`=1011
- Single module, no sub-module. Counters, FSM and response registers are each small.

## Test plan
- Core read only, address 0x10, mem word 0xDEADBEEF → `core_gnt`=1 same cycle, `mem_addr`=0x10, next cycle `core_rvalid`=1, `core_rdata`=0xDEADBEEF.
- Both request continuously, no lock, `STARVE_MAX`=4 → core granted 4 cycles, DMA 1, pattern repeats. `dma_gnt` never low more than 4 consecutive cycles.
- DMA write 0x000000AA strobe 0001 to 0x20 while core idle → `mem_we`=1, `mem_wstrb`=0001. Core byte read of 0x20 later returns 0x000000AA.
- DMA lock burst with core requesting, `LOCK_MAX`=8 → exactly 8 DMA grants, then core granted next cycle, state back to `S_SHARED`.
- `rst` pulsed during `S_LOCK` with a DMA read just granted → following cycle `dma_rvalid`=0 and core granted if requesting.
- No requests → all `mem_*`=0, no grants, no `rvalid`.
